// File: rtl/unidade_controle_param.sv
// unidade_controle_param: turn controller for parametrised ultimate tic-tac-toe.
// Sequences macro-board choice and micro-board move, retries invalid moves,
// rotates among N_JOGADORES players, counts moves and flags a draw at MAX_JOGADAS.
// Optional per-move timeout enabled by defining the macro JOGADA_TIMEOUT_EN.
module unidade_controle_param #(
  parameter int N_JOGADORES    = 2,
  parameter int MAX_JOGADAS    = 81,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       jogada_valida,
  input  logic       fim_jogo,
  input  logic       escolhe_macro,
  output logic       sinal_macro,
  output logic       troca_jogador,
  output logic       zeraR_macro,
  output logic       zeraR_micro,
  output logic       zeraEdge,
  output logic       registraR_macro,
  output logic       registraR_micro,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic       erro_jogada,
  output logic       estouro_tempo,
  output logic       empate,
  output logic       pronto,
  output logic [1:0] jogador_atual,
  output logic [6:0] num_jogadas,
  output logic [3:0] db_estado
);

  // Reject configurations the 2-bit player index / 7-bit move counter cannot hold.
  if (N_JOGADORES < 2 || N_JOGADORES > 4 || MAX_JOGADAS < 1 || MAX_JOGADAS > 127 ||
      TIMEOUT_CICLOS < 1) begin : g_param_invalido
    $error("unidade_controle_param: parameter out of range");
  end

  localparam logic [1:0] ULTIMO_JOGADOR = 2'(N_JOGADORES - 1);
  localparam logic [6:0] MAX_J          = 7'(MAX_JOGADAS);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    JOGA_MACRO     = 4'h2,
    REGISTRA_MACRO = 4'h3,
    JOGA_MICRO     = 4'h4,
    REGISTRA_MICRO = 4'h5,
    TROCAR_JOGADOR = 4'h6,
    DECIDE_MACRO   = 4'h7,
    VALIDA_MACRO   = 4'h8,
    VALIDA_MICRO   = 4'h9,
    ERRO           = 4'hA,
    ESTOURO        = 4'hB,
    FIM            = 4'hF
  } estado_t;

  typedef struct packed {
    logic sinal_macro;
    logic troca;
    logic zera_macro;
    logic zera_micro;
    logic zera_edge;
    logic reg_macro;
    logic reg_micro;
    logic jogar_macro;
    logic jogar_micro;
    logic erro;
    logic estouro;
    logic pronto;
  } saidas_t;

  // Moore decode: the output word that belongs to a given state.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      INICIAL: begin
        s.zera_macro = 1'b1;
        s.zera_micro = 1'b1;
        s.zera_edge  = 1'b1;
      end
      PREPARACAO: begin
        s.zera_macro = 1'b1;
        s.zera_micro = 1'b1;
      end
      JOGA_MACRO: begin
        s.sinal_macro = 1'b1;
        s.jogar_macro = 1'b1;
      end
      VALIDA_MACRO:   s.sinal_macro = 1'b1;
      REGISTRA_MACRO: begin
        s.sinal_macro = 1'b1;
        s.reg_macro   = 1'b1;
      end
      JOGA_MICRO:     s.jogar_micro = 1'b1;
      VALIDA_MICRO:   s = '0;
      REGISTRA_MICRO: s.reg_micro = 1'b1;
      TROCAR_JOGADOR: s.troca = 1'b1;
      DECIDE_MACRO:   s.zera_micro = 1'b1;
      ERRO: begin
        s.erro      = 1'b1;
        s.zera_edge = 1'b1;
      end
      ESTOURO: begin
        s.troca     = 1'b1;
        s.zera_edge = 1'b1;
`ifdef JOGADA_TIMEOUT_EN
        s.estouro   = 1'b1;
`endif
      end
      FIM:     s.pronto = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  estado_t    estado_r;
  estado_t    proximo_s;
  saidas_t    saidas_r;
  logic       origem_r;
  logic       origem_prox_s;
  logic       timeout_s;
  logic [1:0] jogador_r;
  logic [6:0] num_r;
  logic       empate_r;

`ifdef JOGADA_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT_CICLOS - 1);

  logic [TW-1:0] timer_r;
  logic          em_espera_s;

  assign em_espera_s = (estado_r == JOGA_MACRO) || (estado_r == JOGA_MICRO);
  assign timeout_s   = em_espera_s && (timer_r == TIMER_LIM);

  // Per-move timer: counts while waiting in a joga_* state, restarts on every entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_r <= '0;
    end else if (em_espera_s && (proximo_s == estado_r)) begin
      timer_r <= timer_r + TW'(1);
    end else begin
      timer_r <= '0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic; a move strobe in the last timer cycle takes priority over the timeout.
  always_comb begin
    proximo_s     = INICIAL;
    origem_prox_s = origem_r;
    case (estado_r)
      INICIAL: begin
        if (iniciar) proximo_s = PREPARACAO;
        else         proximo_s = INICIAL;
      end
      PREPARACAO: proximo_s = JOGA_MACRO;
      JOGA_MACRO: begin
        if (tem_jogada) begin
          proximo_s = VALIDA_MACRO;
        end else if (timeout_s) begin
          proximo_s     = ESTOURO;
          origem_prox_s = 1'b0;
        end else begin
          proximo_s = JOGA_MACRO;
        end
      end
      VALIDA_MACRO: begin
        if (jogada_valida) begin
          proximo_s = REGISTRA_MACRO;
        end else begin
          proximo_s     = ERRO;
          origem_prox_s = 1'b0;
        end
      end
      REGISTRA_MACRO: proximo_s = JOGA_MICRO;
      JOGA_MICRO: begin
        if (tem_jogada) begin
          proximo_s = VALIDA_MICRO;
        end else if (timeout_s) begin
          proximo_s     = ESTOURO;
          origem_prox_s = 1'b1;
        end else begin
          proximo_s = JOGA_MICRO;
        end
      end
      VALIDA_MICRO: begin
        if (jogada_valida) begin
          proximo_s = REGISTRA_MICRO;
        end else begin
          proximo_s     = ERRO;
          origem_prox_s = 1'b1;
        end
      end
      REGISTRA_MICRO: proximo_s = TROCAR_JOGADOR;
      TROCAR_JOGADOR: begin
        if (fim_jogo || (num_r == MAX_J)) proximo_s = FIM;
        else                              proximo_s = DECIDE_MACRO;
      end
      DECIDE_MACRO: begin
        if (escolhe_macro) proximo_s = PREPARACAO;
        else               proximo_s = REGISTRA_MACRO;
      end
      ERRO, ESTOURO: begin
        if (origem_r) proximo_s = JOGA_MICRO;
        else          proximo_s = JOGA_MACRO;
      end
      FIM: begin
        if (iniciar) proximo_s = INICIAL;
        else         proximo_s = FIM;
      end
      default: proximo_s = INICIAL;
    endcase
  end

  // State register with outputs registered alongside it, plus move/player counters and draw flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r  <= INICIAL;
      saidas_r  <= decodifica(INICIAL);
      origem_r  <= 1'b0;
      jogador_r <= 2'd0;
      num_r     <= 7'd0;
      empate_r  <= 1'b0;
    end else begin
      estado_r <= proximo_s;
      saidas_r <= decodifica(proximo_s);
      origem_r <= origem_prox_s;
      if (estado_r == INICIAL) begin
        jogador_r <= 2'd0;
        num_r     <= 7'd0;
        empate_r  <= 1'b0;
      end else begin
        if ((estado_r == REGISTRA_MICRO) && (num_r != MAX_J)) begin
          num_r <= num_r + 7'd1;
        end
        if ((estado_r == TROCAR_JOGADOR) || (estado_r == ESTOURO)) begin
          if (jogador_r == ULTIMO_JOGADOR) jogador_r <= 2'd0;
          else                             jogador_r <= jogador_r + 2'd1;
        end
        if ((estado_r == TROCAR_JOGADOR) && (num_r == MAX_J) && !fim_jogo) begin
          empate_r <= 1'b1;
        end
      end
    end
  end

  assign sinal_macro     = saidas_r.sinal_macro;
  assign troca_jogador   = saidas_r.troca;
  assign zeraR_macro     = saidas_r.zera_macro;
  assign zeraR_micro     = saidas_r.zera_micro;
  assign zeraEdge        = saidas_r.zera_edge;
  assign registraR_macro = saidas_r.reg_macro;
  assign registraR_micro = saidas_r.reg_micro;
  assign jogar_macro     = saidas_r.jogar_macro;
  assign jogar_micro     = saidas_r.jogar_micro;
  assign erro_jogada     = saidas_r.erro;
  assign estouro_tempo   = saidas_r.estouro;
  assign pronto          = saidas_r.pronto;
  assign empate          = empate_r;
  assign jogador_atual   = jogador_r;
  assign num_jogadas     = num_r;
  assign db_estado       = estado_r;

endmodule

// File: tb/tb_unidade_controle_param.sv
// Testbench for unidade_controle_param (N=3 players, draw at 4 moves, 8-cycle timeout).
module tb_unidade_controle_param;
  localparam int N    = 3;
  localparam int MAXJ = 4;
  localparam int TOUT = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0, tem_jogada = 1'b0, jogada_valida = 1'b0;
  logic       fim_jogo = 1'b0, escolhe_macro = 1'b0;
  logic       sinal_macro, troca_jogador, zeraR_macro, zeraR_micro, zeraEdge;
  logic       registraR_macro, registraR_micro, jogar_macro, jogar_micro;
  logic       erro_jogada, estouro_tempo, empate, pronto;
  logic [1:0] jogador_atual;
  logic [6:0] num_jogadas;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  unidade_controle_param #(.N_JOGADORES(N), .MAX_JOGADAS(MAXJ), .TIMEOUT_CICLOS(TOUT)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
    .jogada_valida(jogada_valida), .fim_jogo(fim_jogo), .escolhe_macro(escolhe_macro),
    .sinal_macro(sinal_macro), .troca_jogador(troca_jogador), .zeraR_macro(zeraR_macro),
    .zeraR_micro(zeraR_micro), .zeraEdge(zeraEdge), .registraR_macro(registraR_macro),
    .registraR_micro(registraR_micro), .jogar_macro(jogar_macro), .jogar_micro(jogar_micro),
    .erro_jogada(erro_jogada), .estouro_tempo(estouro_tempo), .empate(empate),
    .pronto(pronto), .jogador_atual(jogador_atual), .num_jogadas(num_jogadas),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nome, atual, esperado, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected output word for a state, straight from the output table.
  task automatic check_saidas(input string nome, input logic [3:0] st);
    logic [11:0] esp, atu;
    logic        est;
`ifdef JOGADA_TIMEOUT_EN
    est = (st == 4'hB);
`else
    est = 1'b0;
`endif
    esp = {st == 4'h2 || st == 4'h8 || st == 4'h3,
           st == 4'h6 || st == 4'hB,
           st == 4'h0 || st == 4'h1,
           st == 4'h0 || st == 4'h1 || st == 4'h7,
           st == 4'h0 || st == 4'hA || st == 4'hB,
           st == 4'h3, st == 4'h5, st == 4'h2, st == 4'h4, st == 4'hA, est, st == 4'hF};
    atu = {sinal_macro, troca_jogador, zeraR_macro, zeraR_micro, zeraEdge, registraR_macro,
           registraR_micro, jogar_macro, jogar_micro, erro_jogada, estouro_tempo, pronto};
    check(nome, {20'd0, atu}, {20'd0, esp});
  endtask

  task automatic espera(input logic [3:0] cod, input int limite, input string nome);
    int k = 0;
    while (db_estado !== cod && k < limite) begin
      tick();
      k++;
    end
    check(nome, {28'd0, db_estado}, {28'd0, cod});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {iniciar, tem_jogada, jogada_valida, fim_jogo, escolhe_macro} = 5'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic       ini, tem, val, fim, esc;
    logic [3:0] st;
    logic [1:0] jog;
    logic [6:0] num;
  } vet_t;

  // One randomized game checked against a counter-level model of the rules.
  task automatic jogo(input int g);
    int m_jog = 0, m_num = 0, guard = 0;
    bit precisa_macro = 1'b1, acabou = 1'b0, ok, ganha;
    if (db_estado == 4'hF) begin
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      check("fim_to_inicial", {28'd0, db_estado}, 32'h0);
    end
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    check("start_state", {28'd0, db_estado}, 32'h1);
    check("start_zeraR_macro", {31'd0, zeraR_macro}, 32'd1);
    check("start_jog", {30'd0, jogador_atual}, 32'd0);
    check("start_num", {25'd0, num_jogadas}, 32'd0);
    check("start_empate", {31'd0, empate}, 32'd0);
    while (!acabou && guard < 60) begin
      guard++;
      if (precisa_macro) begin
        espera(4'h2, 10, "wait_joga_macro");
        repeat ($urandom_range(0, 3)) tick();
        tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
        check("valida_macro", {28'd0, db_estado}, 32'h8);
        ok = ($urandom_range(0, 3) != 0);
        jogada_valida = ok; tick(); jogada_valida = 1'b0;
        if (!ok) begin
          check("erro_macro", {28'd0, db_estado}, 32'hA);
          check_saidas("erro_macro_out", 4'hA);
          continue;
        end
        check("reg_macro", {28'd0, db_estado}, 32'h3);
        precisa_macro = 1'b0;
      end
      espera(4'h4, 10, "wait_joga_micro");
      repeat ($urandom_range(0, 3)) tick();
      tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
      check("valida_micro", {28'd0, db_estado}, 32'h9);
      ok = ($urandom_range(0, 3) != 0);
      jogada_valida = ok; tick(); jogada_valida = 1'b0;
      if (!ok) begin
        check("erro_micro", {28'd0, db_estado}, 32'hA);
        check("erro_micro_num", {25'd0, num_jogadas}, m_num);
        continue;
      end
      check_saidas("reg_micro_out", 4'h5);
      check("reg_micro_num", {25'd0, num_jogadas}, m_num);
      tick();
      m_num = (m_num + 1 > MAXJ) ? MAXJ : m_num + 1;
      check_saidas("trocar_out", 4'h6);
      check("trocar_num", {25'd0, num_jogadas}, m_num);
      ganha = (g == 1) ? (m_num == MAXJ) : ((g != 0) && ($urandom_range(0, 9) == 0));
      fim_jogo = ganha; tick(); fim_jogo = 1'b0;
      m_jog = (m_jog + 1) % N;
      check("turn_jog", {30'd0, jogador_atual}, m_jog);
      if (ganha || m_num == MAXJ) begin
        check("fim_state", {28'd0, db_estado}, 32'hF);
        check("fim_pronto", {31'd0, pronto}, 32'd1);
        check("fim_empate", {31'd0, empate}, (!ganha && m_num == MAXJ) ? 32'd1 : 32'd0);
        acabou = 1'b1;
      end else begin
        check_saidas("decide_out", 4'h7);
        precisa_macro = ($urandom_range(0, 1) == 1);
        escolhe_macro = precisa_macro; tick(); escolhe_macro = 1'b0;
        check("decide_next", {28'd0, db_estado}, precisa_macro ? 32'h1 : 32'h3);
      end
    end
    check("game_ended", {31'd0, acabou}, 32'd1);
  endtask

  initial begin
    vet_t tab[$];
    logic e;

    // Reset state
    do_reset();
    check("reset_state", {28'd0, db_estado}, 32'h0);
    check_saidas("reset_out", 4'h0);
    check("reset_jog", {30'd0, jogador_atual}, 32'd0);
    check("reset_num", {25'd0, num_jogadas}, 32'd0);
    check("reset_empate", {31'd0, empate}, 32'd0);

    //             ini   tem   val   fim   esc   st     jog   num
    tab.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 2'd0, 7'd0});
    tab.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h8, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 2'd0, 7'd0});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 2'd0, 7'd1});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 2'd1, 7'd1});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 2'd1, 7'd1});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 2'd1, 7'd1});
    tab.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 2'd1, 7'd1});
    tab.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 2'd1, 7'd1});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 2'd1, 7'd2});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 2'd2, 7'd2});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 2'd2, 7'd2});
    tab.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 2'd2, 7'd2});

    foreach (tab[i]) begin
      {iniciar, tem_jogada, jogada_valida, fim_jogo, escolhe_macro} =
        {tab[i].ini, tab[i].tem, tab[i].val, tab[i].fim, tab[i].esc};
      tick();
      check($sformatf("vec%0d_state", i), {28'd0, db_estado}, {28'd0, tab[i].st});
      check($sformatf("vec%0d_jog", i), {30'd0, jogador_atual}, {30'd0, tab[i].jog});
      check($sformatf("vec%0d_num", i), {25'd0, num_jogadas}, {25'd0, tab[i].num});
      check_saidas($sformatf("vec%0d_out", i), tab[i].st);
    end
    {iniciar, tem_jogada, jogada_valida, fim_jogo, escolhe_macro} = 5'b0;

    // Mid-game reset with player 1 waiting in joga_micro
    do_reset();
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    espera(4'h2, 4, "mr_joga_macro");
    tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
    jogada_valida = 1'b1; tick(); jogada_valida = 1'b0;
    espera(4'h4, 4, "mr_joga_micro1");
    tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
    jogada_valida = 1'b1; tick(); jogada_valida = 1'b0;
    espera(4'h7, 4, "mr_decide");
    tick();
    espera(4'h4, 4, "mr_joga_micro2");
    check("mr_jog_before", {30'd0, jogador_atual}, 32'd1);
    reset = 1'b0;
    #1;
    check("mr_state", {28'd0, db_estado}, 32'h0);
    check("mr_jog", {30'd0, jogador_atual}, 32'd0);
    check("mr_num", {25'd0, num_jogadas}, 32'd0);
    check_saidas("mr_out", 4'h0);
    tick();
    reset = 1'b1;

    // Randomized games: game 0 is a forced draw, game 1 a win on the final move
    for (int g = 0; g < 8; g++) jogo(g);

    // Timeout behaviour
    if (db_estado == 4'hF) begin
      iniciar = 1'b1; tick(); iniciar = 1'b0;
    end
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    tick();
    check("to_enter", {28'd0, db_estado}, 32'h2);
`ifdef JOGADA_TIMEOUT_EN
    repeat (TOUT - 1) begin
      tick();
      check("to_idle", {28'd0, db_estado}, 32'h2);
    end
    tick();
    check("to_estouro", {28'd0, db_estado}, 32'hB);
    check_saidas("to_estouro_out", 4'hB);
    tick();
    check("to_back", {28'd0, db_estado}, 32'h2);
    check("to_jog", {30'd0, jogador_atual}, 32'd1);
    check("to_num", {25'd0, num_jogadas}, 32'd0);
    repeat (TOUT - 1) tick();
    tem_jogada = 1'b1; tick(); tem_jogada = 1'b0;
    check("to_move_wins", {28'd0, db_estado}, 32'h8);
`else
    e = 1'b0;
    repeat (3 * TOUT) begin
      tick();
      e = e | estouro_tempo | (db_estado != 4'h2);
    end
    check("no_timeout", {31'd0, e}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
